// File: rtl/deser_1b_128.sv
// ---------------------------------------------------------------------------
// deser_1b_128
//   Serial-to-parallel deserializer. Collects a 1-bit val/rdy stream,
//   LSB-first, into an NBITS-wide word. The word is then held on a val/rdy
//   output until the consumer takes it.
//
//   Ports
//     clk      : clock, all state updates on the rising edge
//     reset    : asynchronous, active-low reset
//     in_val   : serial bit valid
//     in_rdy   : serial bit ready (1 while filling, follows out_rdy when full)
//     in_      : serial data bit
//     out_val  : assembled word valid
//     out_rdy  : assembled word ready
//     out      : assembled word, bit k = k-th bit received for that word
//     idx      : next bit position to be written (status/debug)
//
//   NBITS must be at least 2.
// ---------------------------------------------------------------------------
module deser_1b_128 #(
  parameter int NBITS = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic                     in_,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [NBITS-1:0]         out,
  output logic [$clog2(NBITS)-1:0] idx
);

  localparam int             IW       = $clog2(NBITS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NBITS - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_next_idx;
  logic [NBITS-1:0] r_out;
  logic             w_in_fire;

  // Next-state and handshake outputs. Outputs depend only on state and
  // out_rdy, so in_val/in_ never reach an output combinationally.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_next_idx   = r_idx;
    in_rdy       = 1'b1;
    out_val      = 1'b0;

    unique case (r_state)
      ST_FILL: begin
        if (in_val) begin
          if (r_idx == LAST_IDX) begin
            w_next_idx   = '0;
            w_next_state = ST_FULL;
          end else begin
            w_next_idx = r_idx + IW'(1);
          end
        end
      end

      ST_FULL: begin
        out_val = 1'b1;
        in_rdy  = out_rdy;
        if (out_rdy) begin
          // Word leaves this edge. A bit arriving on the same edge becomes
          // bit 0 of the next word, so a continuous stream has no bubble.
          w_next_state = ST_FILL;
          w_next_idx   = in_val ? IW'(1) : '0;
        end
      end

      default: begin
        w_next_state = ST_FILL;
        w_next_idx   = '0;
      end
    endcase
  end

  assign w_in_fire = in_val & in_rdy;

  // r_idx is always 0 in FULL, so an accepted bit in FULL lands in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FILL;
      r_idx   <= '0;
      // NOTE: the word register is wide but still reset, because out must
      // read zero immediately while reset is asserted.
      r_out   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_in_fire) begin
        r_out[r_idx] <= in_;
      end
    end
  end

  assign out = r_out;
  assign idx = r_idx;

endmodule

// File: tb/tb_deser_1b_128.sv
// ---------------------------------------------------------------------------
// tb_deser_1b_128
//   Self-checking bench for deser_1b_128. Stimulus pushes each expected word
//   into a scoreboard queue; a monitor pops and compares on every output
//   transfer. Direct checks cover reset values, stall stability and idx.
// ---------------------------------------------------------------------------
module tb_deser_1b_128;

  localparam int NB = 128;

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic          in_;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out;
  logic [6:0]    idx;

  deser_1b_128 #(.NBITS(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_     (in_),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out),
    .idx     (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int n_words  = 0;
  int last_fire = 0;
  int prev_fire = 0;
  bit rnd_on   = 1'b0;

  logic [NB-1:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [NB-1:0] act,
                       input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: an output transfer happens at the next posedge when both
  // out_val and out_rdy are high at this negedge.
  always @(negedge clk) begin
    if (reset && out_val && out_rdy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_word: got %h, required no word", out);
      end else begin
        check("sb_word", out, sb_q.pop_front());
      end
      n_words++;
      prev_fire = last_fire;
      last_fire = cyc;
    end
  end

  // Random out_rdy back-pressure for the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Offers one bit and waits (bounded) until it is accepted.
  task automatic send_bit(input logic b);
    bit acc;
    int n;
    acc    = 1'b0;
    n      = 0;
    in_val = 1'b1;
    in_    = b;
    do begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: got in_rdy=0 for %0d cycles, required acceptance", n);
    end
    in_val = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] w;
    int            acc;
    int            n;
    int            words_before;

    reset   = 1'b0;
    in_val  = 1'b0;
    in_     = 1'b0;
    out_rdy = 1'b0;

    // ---------------- 1: reset values ----------------
    @(negedge clk);
    check("rst_out_val", 128'(out_val), 128'(0));
    check("rst_in_rdy",  128'(in_rdy),  128'(1));
    check("rst_idx",     128'(idx),     128'(0));
    check("rst_out",     out,           '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_out_val", 128'(out_val), 128'(0));
      check("idle_in_rdy",  128'(in_rdy),  128'(1));
      check("idle_idx",     128'(idx),     128'(0));
      check("idle_out",     out,           '0);
      @(posedge clk);
      #1;
    end

    // ---------------- 2: full word, stalled ----------------
    sb_q.push_back(128'h8000_0010_0000_0000_0000_0000_0000_8001);
    for (int k = 0; k < NB; k++) begin
      in_val = 1'b1;
      in_    = (k == 0 || k == 15 || k == 100 || k == 127);
      if (k == NB - 1) begin
        @(negedge clk);
        check("t2_not_yet_valid", 128'(out_val), 128'(0));
        check("t2_last_idx",      128'(idx),     128'(127));
      end
      @(posedge clk);
      #1;
    end
    for (int h = 0; h < 4; h++) begin
      in_ = h[0];
      @(negedge clk);
      check("t2_out_val", 128'(out_val), 128'(1));
      check("t2_out",     out, 128'h8000_0010_0000_0000_0000_0000_0000_8001);
      check("t2_idx",     128'(idx),     128'(0));
      check("t2_in_rdy",  128'(in_rdy),  128'(0));
      @(posedge clk);
      #1;
    end

    // ---------------- 3: back-to-back consume + refill ----------------
    sb_q.push_back(128'h1);
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_     = 1'b1;
    @(negedge clk);
    check("t3_pass_in_rdy", 128'(in_rdy), 128'(1));
    @(posedge clk);
    #1;
    in_ = 1'b0;
    @(negedge clk);
    check("t3_out_val_fell", 128'(out_val), 128'(0));
    check("t3_idx_one",      128'(idx),     128'(1));
    check("t3_out_bit0",     128'(out[0]),  128'(1));
    repeat (NB - 1) begin
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    @(negedge clk);
    check("t3_rise", 128'(out_val), 128'(1));
    @(posedge clk);
    #1;
    check("t3_word_period", 128'(last_fire - prev_fire), 128'(NB));

    // ---------------- 4: bursty input ----------------
    sb_q.push_back('1);
    acc = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      in_val = (i % 2 == 0);
      in_    = 1'b1;
      @(negedge clk);
      if (i % 50 == 3) check("t4_idx", 128'(idx), 128'(acc % NB));
      if (i == 2 * NB - 2) check("t4_before_last", 128'(out_val), 128'(0));
      if (i == 2 * NB - 1) begin
        check("t4_valid", 128'(out_val), 128'(1));
        check("t4_idx_wrap", 128'(idx), 128'(0));
      end
      if (in_val && in_rdy) acc++;
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    @(negedge clk);
    check("t4_consumed", 128'(out_val), 128'(0));
    @(posedge clk);
    #1;

    // ---------------- 5: reset mid-word and while full ----------------
    out_rdy = 1'b0;
    for (int k = 0; k < 50; k++) send_bit(1'b1);
    check("t5_partial_idx", 128'(idx), 128'(50));
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_idx", 128'(idx), 128'(0));
    check("t5_rst_out", out, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < NB; k++) send_bit(k[0]);
    @(negedge clk);
    check("t5_valid", 128'(out_val), 128'(1));
    check("t5_word",  out, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_out_val", 128'(out_val), 128'(0));
    check("t5_async_out",     out,           '0);
    check("t5_async_in_rdy",  128'(in_rdy),  128'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ---------------- 6: random words with gaps ----------------
    words_before = n_words;
    rnd_on = 1'b1;
    for (int wn = 0; wn < 20; wn++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      sb_q.push_back(w);
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_bit(w[k]);
      end
    end
    rnd_on  = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("t6_drained",     128'(sb_q.size()),           128'(0));
    check("t6_word_count",  128'(n_words - words_before), 128'(20));
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_extra", 128'(n_words - words_before), 128'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
